// File: rtl/neuron_buffer_rotator.sv
// Neuron buffer rotator: rotates NB neuron buffers between the read role
// (feeding the convolution unit) and the write role (receiving pool results
// and supplying partial sums). A rotation is requested at layer end and runs
// RUN -> DRAIN -> SWAP so that a pool word captured in the last RUN cycle
// still lands in the outgoing write buffer before the roles move on.
module neuron_buffer_rotator #(
   parameter  int depth = 2,
   parameter  int A     = 7,
   parameter  int W     = 16,
   parameter  int NB    = 2,
   localparam int D     = 1 << depth,
   localparam int S     = (NB > 2) ? $clog2(NB) : 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              swapReq,
   output logic              swapAck,
   output logic              poolReady,
   output logic [S-1:0]      rdSel,
   output logic [S-1:0]      wrSel,
   output logic [7:0]        layerCount,
   input  logic [A-1:0]      readBuffAddress,
   input  logic [A-1:0]      writeBuffAddress,
   output logic [NB*A-1:0]   bufAddress,
   output logic [NB-1:0]     bufWE,
   output logic [NB*W*D-1:0] toBufIn,
   input  logic [NB*W*D-1:0] fromBuf,
   input  logic [W*D-1:0]    fromPoolUnitOut,
   input  logic              poolValid,
   output logic [W*D-1:0]    toConvUnitNBuffIn,
   output logic [W*D-1:0]    toConvUnitPartialSum
);

   localparam int WD = W * D;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      SWAP  = 2'd2
   } stateType;

   stateType       state;
   logic           wrPending;
   logic [A-1:0]   wrAddress;
   logic [WD-1:0]  wrData;
   logic           writeFire;
   logic           capture;
   logic [WD-1:0]  rdWord;
   logic [WD-1:0]  wrWord;

   // Pool words are only accepted while running and never while reset is held.
   assign poolReady = (state == RUN) && !RST;
   assign capture   = poolValid && poolReady;

   // A pending write is dropped in the cycle reset arrives, so an aborted
   // rotation never commits its last pool word.
   assign writeFire = wrPending && !RST;

   // Rotation sequencer: owns the buffer roles, layer counter and ack pulse.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and the order of statements does not matter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= RUN;
         rdSel      <= '0;
         wrSel      <= S'(1);
         layerCount <= '0;
         swapAck    <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               swapAck <= 1'b0;
               if (swapReq) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // The captured word is written this cycle; ack shows during SWAP.
               state   <= SWAP;
               swapAck <= 1'b1;
            end
            SWAP: begin
               state      <= RUN;
               swapAck    <= 1'b0;
               rdSel      <= wrSel;
               wrSel      <= (wrSel == S'(NB - 1)) ? '0 : wrSel + S'(1);
               layerCount <= layerCount + 8'd1;
            end
            default: begin
               state   <= RUN;
               swapAck <= 1'b0;
            end
         endcase
      end
   end

   // One-entry write register: holds a pool word for exactly one cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wrPending <= 1'b0;
         wrAddress <= '0;
         wrData    <= '0;
      end else begin
         wrPending <= capture;
         if (capture) begin
            wrAddress <= writeBuffAddress;
            wrData    <= fromPoolUnitOut;
         end
      end
   end

   // Select the read-buffer and write-buffer words out of the flat bus.
   // NOTE: every variable gets a default first so no latch is inferred.
   always_comb begin
      rdWord = '0;
      wrWord = '0;
      for (int i = 0; i < NB; i++) begin
         if (S'(i) == rdSel) begin
            rdWord = fromBuf[i*WD +: WD];
         end
         if (S'(i) == wrSel) begin
            wrWord = fromBuf[i*WD +: WD];
         end
      end
   end

   // Registered conv-unit feeds: input activations and partial sums.
   always_ff @(posedge CLK) begin
      if (RST) begin
         toConvUnitNBuffIn    <= '0;
         toConvUnitPartialSum <= '0;
      end else begin
         toConvUnitNBuffIn    <= rdWord;
         toConvUnitPartialSum <= wrWord;
      end
   end

   // Route addresses, write enables and write data to each buffer by role;
   // buffers holding neither role see all zeros.
   always_comb begin
      bufAddress = '0;
      bufWE      = '0;
      toBufIn    = '0;
      for (int i = 0; i < NB; i++) begin
         if (S'(i) == rdSel) begin
            bufAddress[i*A +: A] = readBuffAddress;
         end else if (S'(i) == wrSel) begin
            bufAddress[i*A +: A] = writeFire ? wrAddress : writeBuffAddress;
            bufWE[i]             = writeFire;
            toBufIn[i*WD +: WD]  = writeFire ? wrData : '0;
         end
      end
   end

endmodule

// File: tb/tb_neuron_buffer_rotator.sv
// Bench for neuron_buffer_rotator: one NB=2 and one NB=3 instance share the
// same stimulus. Expected buffer writes go into per-instance queues when a
// pool word is offered and are popped when the instance raises a write enable.
module tb_neuron_buffer_rotator;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          swapReq = 1'b0;
   logic          poolValid = 1'b0;
   logic [6:0]    readBuffAddress = 7'd10;
   logic [6:0]    writeBuffAddress = 7'd11;
   logic [63:0]   fromPoolUnitOut = '0;
   logic [127:0]  fromBuf2;
   logic [191:0]  fromBuf3;

   logic          swapAck2, poolReady2;
   logic [0:0]    rdSel2, wrSel2;
   logic [7:0]    layerCount2;
   logic [13:0]   bufAddress2;
   logic [1:0]    bufWE2;
   logic [127:0]  toBufIn2;
   logic [63:0]   conv2Rd, conv2Ps;

   logic          swapAck3, poolReady3;
   logic [1:0]    rdSel3, wrSel3;
   logic [7:0]    layerCount3;
   logic [20:0]   bufAddress3;
   logic [2:0]    bufWE3;
   logic [191:0]  toBufIn3;
   logic [63:0]   conv3Rd, conv3Ps;

   typedef struct {
      int          buffer;
      logic [6:0]  addr;
      logic [63:0] data;
   } wrExpT;

   wrExpT q2[$];
   wrExpT q3[$];
   wrExpT monE2, monE3;

   int checks = 0;
   int errors = 0;
   int expRd2, expRd3, expLayer;

   always #5 CLK = ~CLK;

   neuron_buffer_rotator #(.depth(2), .A(7), .W(16), .NB(2)) dut2 (
      .CLK(CLK), .RST(RST), .swapReq(swapReq), .swapAck(swapAck2),
      .poolReady(poolReady2), .rdSel(rdSel2), .wrSel(wrSel2),
      .layerCount(layerCount2), .readBuffAddress(readBuffAddress),
      .writeBuffAddress(writeBuffAddress), .bufAddress(bufAddress2),
      .bufWE(bufWE2), .toBufIn(toBufIn2), .fromBuf(fromBuf2),
      .fromPoolUnitOut(fromPoolUnitOut), .poolValid(poolValid),
      .toConvUnitNBuffIn(conv2Rd), .toConvUnitPartialSum(conv2Ps)
   );

   neuron_buffer_rotator #(.depth(2), .A(7), .W(16), .NB(3)) dut3 (
      .CLK(CLK), .RST(RST), .swapReq(swapReq), .swapAck(swapAck3),
      .poolReady(poolReady3), .rdSel(rdSel3), .wrSel(wrSel3),
      .layerCount(layerCount3), .readBuffAddress(readBuffAddress),
      .writeBuffAddress(writeBuffAddress), .bufAddress(bufAddress3),
      .bufWE(bufWE3), .toBufIn(toBufIn3), .fromBuf(fromBuf3),
      .fromPoolUnitOut(fromPoolUnitOut), .poolValid(poolValid),
      .toConvUnitNBuffIn(conv3Rd), .toConvUnitPartialSum(conv3Ps)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic pushWrite(input logic [6:0] addr, input logic [63:0] data,
                            input int buf2, input int buf3);
      wrExpT e;
      e.addr   = addr;
      e.data   = data;
      e.buffer = buf2;
      q2.push_back(e);
      e.buffer = buf3;
      q3.push_back(e);
   endtask

   // Write monitor: every asserted write enable must match the oldest expected write.
   always @(negedge CLK) begin
      if (bufWE2 !== 2'b00) begin
         if (q2.size() == 0) begin
            check("spuriousWrite2", 64'(bufWE2), 64'd0);
         end else begin
            monE2 = q2.pop_front();
            check("wr2We", 64'(bufWE2), 64'd1 << monE2.buffer);
            check("wr2Addr", 64'(bufAddress2[monE2.buffer*7 +: 7]), 64'(monE2.addr));
            check("wr2Data", toBufIn2[monE2.buffer*64 +: 64], monE2.data);
         end
      end
      if (bufWE3 !== 3'b000) begin
         if (q3.size() == 0) begin
            check("spuriousWrite3", 64'(bufWE3), 64'd0);
         end else begin
            monE3 = q3.pop_front();
            check("wr3We", 64'(bufWE3), 64'd1 << monE3.buffer);
            check("wr3Addr", 64'(bufAddress3[monE3.buffer*7 +: 7]), 64'(monE3.addr));
            check("wr3Data", toBufIn3[monE3.buffer*64 +: 64], monE3.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      fromBuf2 = {64'd2, 64'd1};
      fromBuf3 = {64'd3, 64'd2, 64'd1};

      // Reset held for two edges.
      step();
      step();
      @(negedge CLK);
      check("rstRdSel2", 64'(rdSel2), 64'd0);
      check("rstWrSel2", 64'(wrSel2), 64'd1);
      check("rstWrSel3", 64'(wrSel3), 64'd1);
      check("rstLayer2", 64'(layerCount2), 64'd0);
      check("rstWe2", 64'(bufWE2), 64'd0);
      check("rstWe3", 64'(bufWE3), 64'd0);
      check("rstConvRd2", conv2Rd, 64'd0);
      check("rstConvPs2", conv2Ps, 64'd0);
      check("rstReady2", 64'(poolReady2), 64'd0);
      check("rstAck2", 64'(swapAck2), 64'd0);

      // Release reset: ready straight away, read mux follows addresses.
      step();
      RST = 1'b0;
      @(negedge CLK);
      check("relReady2", 64'(poolReady2), 64'd1);
      check("relReady3", 64'(poolReady3), 64'd1);
      check("rdAddr2", 64'(bufAddress2[0 +: 7]), 64'd10);
      check("wrAddr2", 64'(bufAddress2[7 +: 7]), 64'd11);
      check("idleAddr3", 64'(bufAddress3[14 +: 7]), 64'd0);
      step();
      @(negedge CLK);
      check("convRd2", conv2Rd, 64'd1);
      check("convPs2", conv2Ps, 64'd2);
      check("convRd3", conv3Rd, 64'd1);
      check("convPs3", conv3Ps, 64'd2);

      // Single pool write, address changed after capture.
      step();
      poolValid = 1'b1;
      fromPoolUnitOut = 64'd8;
      writeBuffAddress = 7'd11;
      pushWrite(7'd11, 64'd8, 1, 1);
      step();
      poolValid = 1'b0;
      writeBuffAddress = 7'd20;
      @(negedge CLK);
      check("poolWe2", 64'(bufWE2), 64'h2);
      check("poolWe3", 64'(bufWE3), 64'h2);
      check("poolRdAddr2", 64'(bufAddress2[0 +: 7]), 64'd10);
      check("poolRdData2", toBufIn2[0 +: 64], 64'd0);
      check("poolIdleData3", toBufIn3[128 +: 64], 64'd0);
      step();
      @(negedge CLK);
      check("postWrAddr2", 64'(bufAddress2[7 +: 7]), 64'd20);
      check("postWe2", 64'(bufWE2), 64'd0);

      // Back-to-back pool words.
      for (int k = 0; k < 3; k++) begin
         step();
         poolValid = 1'b1;
         fromPoolUnitOut = 64'(100 + k);
         writeBuffAddress = 7'(30 + k);
         pushWrite(7'(30 + k), 64'(100 + k), 1, 1);
      end
      step();
      poolValid = 1'b0;
      writeBuffAddress = 7'd20;
      step();

      // Swap request with a simultaneous pool word.
      step();
      swapReq = 1'b1;
      poolValid = 1'b1;
      fromPoolUnitOut = 64'h55;
      writeBuffAddress = 7'd40;
      pushWrite(7'd40, 64'h55, 1, 1);
      @(negedge CLK);
      check("reqReady2", 64'(poolReady2), 64'd1);
      check("reqAck2", 64'(swapAck2), 64'd0);
      step();
      swapReq = 1'b0;
      fromPoolUnitOut = 64'h66;
      writeBuffAddress = 7'd41;
      @(negedge CLK);
      check("drainReady2", 64'(poolReady2), 64'd0);
      check("drainAck2", 64'(swapAck2), 64'd0);
      check("drainWe2", 64'(bufWE2), 64'h2);
      check("drainWe3", 64'(bufWE3), 64'h2);
      check("drainRdSel2", 64'(rdSel2), 64'd0);
      step();
      @(negedge CLK);
      check("swapAck2", 64'(swapAck2), 64'd1);
      check("swapAck3", 64'(swapAck3), 64'd1);
      check("swapReady2", 64'(poolReady2), 64'd0);
      check("swapRdSel2", 64'(rdSel2), 64'd0);
      check("swapLayer2", 64'(layerCount2), 64'd0);
      step();
      poolValid = 1'b0;
      writeBuffAddress = 7'd20;
      @(negedge CLK);
      check("postAck2", 64'(swapAck2), 64'd0);
      check("postReady2", 64'(poolReady2), 64'd1);
      check("postRdSel2", 64'(rdSel2), 64'd1);
      check("postWrSel2", 64'(wrSel2), 64'd0);
      check("postRdSel3", 64'(rdSel3), 64'd1);
      check("postWrSel3", 64'(wrSel3), 64'd2);
      check("postLayer2", 64'(layerCount2), 64'd1);
      check("postLayer3", 64'(layerCount3), 64'd1);
      step();
      @(negedge CLK);
      check("swConvRd2", conv2Rd, 64'd2);
      check("swConvPs2", conv2Ps, 64'd1);
      check("swConvRd3", conv3Rd, 64'd2);
      check("swConvPs3", conv3Ps, 64'd3);
      check("swRdAddr2", 64'(bufAddress2[7 +: 7]), 64'd10);
      check("swWrAddr2", 64'(bufAddress2[0 +: 7]), 64'd20);

      // Two back-to-back rotations, pool words offered only outside RUN.
      expRd2 = 1;
      expRd3 = 1;
      expLayer = 1;
      for (int k = 0; k < 6; k++) begin
         step();
         swapReq = 1'b1;
         poolValid = (k % 3) != 0;
         fromPoolUnitOut = 64'(200 + k);
         @(negedge CLK);
         check("loopReady3", 64'(poolReady3), 64'((k % 3) == 0));
         check("loopAck3", 64'(swapAck3), 64'((k % 3) == 2));
         if ((k % 3) == 0) begin
            check("loopRdSel2", 64'(rdSel2), 64'(expRd2));
            check("loopRdSel3", 64'(rdSel3), 64'(expRd3));
            check("loopLayer3", 64'(layerCount3), 64'(expLayer));
         end
         if ((k % 3) == 2) begin
            expRd2 = (expRd2 + 1) % 2;
            expRd3 = (expRd3 + 1) % 3;
            expLayer++;
         end
      end
      step();
      swapReq = 1'b0;
      poolValid = 1'b0;
      @(negedge CLK);
      check("wrapRdSel2", 64'(rdSel2), 64'd1);
      check("wrapWrSel2", 64'(wrSel2), 64'd0);
      check("wrapRdSel3", 64'(rdSel3), 64'd0);
      check("wrapWrSel3", 64'(wrSel3), 64'd1);
      check("wrapLayer2", 64'(layerCount2), 64'd3);
      check("wrapLayer3", 64'(layerCount3), 64'd3);

      // Reset arriving in DRAIN discards the captured word and the rotation.
      step();
      swapReq = 1'b1;
      poolValid = 1'b1;
      fromPoolUnitOut = 64'h77;
      writeBuffAddress = 7'd50;
      step();
      RST = 1'b1;
      swapReq = 1'b0;
      poolValid = 1'b0;
      @(negedge CLK);
      check("abortWe2", 64'(bufWE2), 64'd0);
      check("abortWe3", 64'(bufWE3), 64'd0);
      check("abortAck3", 64'(swapAck3), 64'd0);
      check("abortReady3", 64'(poolReady3), 64'd0);
      step();
      @(negedge CLK);
      check("abortRstAck3", 64'(swapAck3), 64'd0);
      check("abortRdSel2", 64'(rdSel2), 64'd0);
      check("abortRdSel3", 64'(rdSel3), 64'd0);
      check("abortWrSel2", 64'(wrSel2), 64'd1);
      check("abortLayer3", 64'(layerCount3), 64'd0);
      step();
      RST = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         check("afterAck3", 64'(swapAck3), 64'd0);
         check("afterRdSel3", 64'(rdSel3), 64'd0);
         check("afterReady3", 64'(poolReady3), 64'd1);
         step();
      end

      check("queueEmpty2", 64'(q2.size()), 64'd0);
      check("queueEmpty3", 64'(q3.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
